sti_pixel_packer: RTL and testbench
===================================

Name: sti_pixel_packer

Overview:
Downstream stage of the STI_DAC serial transmitter. Consumes the so_data/so_valid bit stream and packs it MSB-first into 8-bit pixels. Writes each pixel to the pixel memory through pixel_wr/pixel_addr/pixel_dataout. After the last frame it zero-fills the remaining pixel addresses and raises pixel_finish.

Parameters:
PIX_DEPTH, 256, number of pixel addresses written (0..PIX_DEPTH-1); must be ≤ 2^ADDR_W
ADDR_W, 8, width of pixel_addr

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
so_data  input  1  serial bit from the transmitter; valid when so_valid=1
so_valid  input  1  qualifies so_data; one bit per cycle while high
pi_end  input  1  level; high during the final frame, held until that frame's so_valid falls
pixel_wr  output  1  write strobe; memory captures on its rising edge
pixel_addr  output  ADDR_W  pixel write address
pixel_dataout  output  8  pixel write data
pixel_finish  output  1  sticky; all PIX_DEPTH addresses written
overflow  output  1  sticky; a complete pixel arrived after the address space was exhausted

Behaviour:
- Reset (reset=0, async): all outputs 0, shift register 0, bit_cnt=0, next_addr=0, pending=0, end_seen=0; write engine in W_IDLE.
- Bit capture: on each edge with so_valid=1 and end_seen=0, sh <= {sh[6:0], so_data} and bit_cnt (3 bit) increments.
- When bit_cnt==7 and so_valid=1, the completed byte {sh[6:0], so_data} goes to the hold register and pending is set. The first received bit is pixel bit 7.
- Packing is continuous across so_valid gaps and frame boundaries. A partial byte is retained while so_valid is low.
- Write engine states:
  - W_IDLE: if pending and next_addr<PIX_DEPTH, load pixel_dataout<=hold and pixel_addr<=next_addr, clear pending, go to W_STROBE.
  - W_STROBE: pixel_wr<=1, go to W_DONE.
  - W_DONE: pixel_wr<=0, next_addr++, go to W_IDLE.
- Write latency: if the 8th bit is sampled at edge T, data and address update at T+1, pixel_wr rises at T+2 and falls at T+3. Address and data are stable for one full cycle before the strobe's rising edge and through its high phase.
- Throughput is at least 1 pixel per 3 cycles, against a maximum arrival rate of 1 per 8 cycles. No pixel may be lost while next_addr<PIX_DEPTH.
- Overflow: a byte completing when next_addr==PIX_DEPTH (including one pending) is discarded, overflow<=1, and no write occurs.
- End detection: so_valid sampled 1→0 while pi_end=1 sets end_seen. After that, so_valid is ignored.
- Flush: on end_seen, if bit_cnt≠0, the partial byte is left-aligned and zero-padded (sh << (8-bit_cnt)), placed in hold, and pending is set. It is written like a normal pixel.
- Fill: after the flush write (or immediately if none), the engine writes 0x00 to next_addr..PIX_DEPTH-1 using the same 3-cycle sequence.
- pixel_finish rises on the edge after the final W_DONE, or one cycle after end_seen if next_addr already equals PIX_DEPTH. It stays high until reset.
- Data arriving simultaneously with an in-progress write goes into the shift register; the hold register is never overwritten while pending=1, which the arrival-rate bound guarantees.
- Reset mid-operation (any state, including fill) aborts immediately with no further pixel_wr. After release, the next stream starts at address 0.

Test Plan:
1. 16-bit frame 0xA55A with pi_end=1 → addr0=A5, addr1=5A, addr2..255=00; exactly 256 pixel_wr pulses; pixel_finish rises about 3×254 cycles after the frame ends.
2. 8-bit frame 0x3C, so_valid low for 5 cycles, then 24-bit frame 0x123456 ending with pi_end → addr0=3C, addr1=12, addr2=34, addr3=56, addr4..255=00.
3. 12 bits 1011_0110_1101 then end → addr0=B6, addr1=D0 (padded), rest 00, overflow=0.
4. PIX_DEPTH=4, 40 bits of 0xFF → four writes of FF at addr0..3, overflow=1 after the 5th byte with no 5th write, pixel_finish one cycle after end_seen and no fill writes.
5. Assert reset while filling at addr 100 → pixel_wr, pixel_addr, pixel_dataout and pixel_finish are 0 asynchronously. After release, byte 0x81 is written to addr0.
6. Strobe timing check on every write: pixel_addr and pixel_dataout unchanged from one cycle before pixel_wr rises until it falls; pixel_wr high exactly 1 cycle.

Source files
------------

// File: rtl/sti_pixel_packer.sv
// -----------------------------------------------------------------------------
// sti_pixel_packer
//
// Downstream stage of the STI_DAC serial transmitter. Packs the so_data bit
// stream MSB-first into 8-bit pixels and writes them to pixel memory with a
// three-step write engine (set up address/data, raise strobe, drop strobe).
// Once the final frame has ended, any partial byte is flushed zero-padded and
// the remaining addresses up to PIX_DEPTH-1 are filled with 0x00.
//
// Stream protocol: so_valid is a pure qualifier with no backpressure. One bit
// is consumed on every rising edge where so_valid=1. A 1->0 transition of
// so_valid sampled while pi_end=1 marks the end of the final frame. After that,
// the stream is ignored until reset.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   reset          asynchronous, active-low reset
//   so_data        serial data bit, valid when so_valid=1
//   so_valid       bit qualifier
//   pi_end         high during the final frame
//   pixel_wr       write strobe, memory captures on its rising edge
//   pixel_addr     pixel write address
//   pixel_dataout  pixel write data
//   pixel_finish   sticky, all PIX_DEPTH addresses written
//   overflow       sticky, a complete pixel arrived with no address left
//
// The write-engine state is held in r_wstate (type wstate_t) for probing.
// -----------------------------------------------------------------------------
module sti_pixel_packer #(
    parameter int PIX_DEPTH = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              so_data,
    input  logic              so_valid,
    input  logic              pi_end,
    output logic              pixel_wr,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [7:0]        pixel_dataout,
    output logic              pixel_finish,
    output logic              overflow
);

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_STROBE = 2'd1,
        W_DONE   = 2'd2
    } wstate_t;

    // One extra bit so that next_addr can hold PIX_DEPTH itself.
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(PIX_DEPTH);

    // Capture / packing state
    logic [7:0]        r_sh;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_hold;
    logic              r_pending;
    logic              r_end_seen;
    logic              r_valid_d;
    logic [ADDR_W:0]   r_next_addr;

    // Write engine and registered outputs
    wstate_t           r_wstate;
    wstate_t           w_wstate_nxt;
    logic              r_pixel_wr;
    logic [ADDR_W-1:0] r_pixel_addr;
    logic [7:0]        r_pixel_data;
    logic              r_finish;
    logic              r_overflow;

    // Combinational helpers
    logic              w_space;
    logic              w_bit_take;
    logic              w_byte_done;
    logic [7:0]        w_byte;
    logic              w_end_evt;
    logic [3:0]        w_pad;
    logic [7:0]        w_flush_byte;
    logic              w_start;
    logic              w_load;
    logic              w_drop;
    logic              w_wr_nxt;
    logic              w_addr_inc;
    logic              w_finish_set;

    assign w_space      = (r_next_addr < LP_DEPTH);
    assign w_bit_take   = so_valid && !r_end_seen;
    assign w_byte_done  = w_bit_take && (r_bit_cnt == 3'd7);
    assign w_byte       = {r_sh[6:0], so_data};
    assign w_end_evt    = !r_end_seen && r_valid_d && !so_valid && pi_end;
    // The partial byte sits in the low bit_cnt bits of the shift register;
    // shifting by 8-bit_cnt left-aligns it and zero-pads the tail.
    assign w_pad        = 4'd8 - {1'b0, r_bit_cnt};
    assign w_flush_byte = r_sh << w_pad;
    // A real (or flushed) pixel always goes before fill zeros.
    assign w_start      = w_space && (r_pending || r_end_seen);

    // -------------------------------------------------------------------------
    // Write engine: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Write engine: next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:   if (w_start) w_wstate_nxt = W_STROBE;
            W_STROBE: w_wstate_nxt = W_DONE;
            W_DONE:   w_wstate_nxt = W_IDLE;
            default:  w_wstate_nxt = W_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Write engine: per-state actions
    // -------------------------------------------------------------------------
    always_comb begin
        w_load       = 1'b0;
        w_drop       = 1'b0;
        w_wr_nxt     = 1'b0;
        w_addr_inc   = 1'b0;
        w_finish_set = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_load       = w_start;
                // A byte still pending when the address space ran out is lost.
                w_drop       = r_pending && !w_space;
                w_finish_set = r_end_seen && !r_pending && !w_space;
            end
            W_STROBE: w_wr_nxt   = 1'b1;
            W_DONE:   w_addr_inc = 1'b1;
            default:  ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Bit capture, hold register, end detection and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sh         <= 8'h00;
            r_bit_cnt    <= 3'd0;
            r_hold       <= 8'h00;
            r_pending    <= 1'b0;
            r_end_seen   <= 1'b0;
            r_valid_d    <= 1'b0;
            r_next_addr  <= '0;
            r_pixel_wr   <= 1'b0;
            r_pixel_addr <= '0;
            r_pixel_data <= 8'h00;
            r_finish     <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_valid_d  <= so_valid;
            r_pixel_wr <= w_wr_nxt;

            if (w_bit_take) begin
                r_sh      <= w_byte;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            // Clear first so that a same-edge set below takes priority.
            if ((w_load && r_pending) || w_drop) begin
                r_pending <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            if (w_byte_done) begin
                if (w_space) begin
                    r_hold    <= w_byte;
                    r_pending <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end

            // so_valid is low on this edge, so no bit capture competes here.
            if (w_end_evt) begin
                r_end_seen <= 1'b1;
                if ((r_bit_cnt != 3'd0) && w_space) begin
                    r_hold    <= w_flush_byte;
                    r_pending <= 1'b1;
                    r_sh      <= 8'h00;
                    r_bit_cnt <= 3'd0;
                end
            end

            if (w_load) begin
                r_pixel_addr <= r_next_addr[ADDR_W-1:0];
                r_pixel_data <= r_pending ? r_hold : 8'h00;
            end

            if (w_addr_inc) begin
                r_next_addr <= r_next_addr + (ADDR_W+1)'(1);
            end

            if (w_finish_set) begin
                r_finish <= 1'b1;
            end
        end
    end

    assign pixel_wr      = r_pixel_wr;
    assign pixel_addr    = r_pixel_addr;
    assign pixel_dataout = r_pixel_data;
    assign pixel_finish  = r_finish;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_sti_pixel_packer.sv
// -----------------------------------------------------------------------------
// tb_sti_pixel_packer
//
// Two packer instances share one stimulus stream: u_dut with 256 pixel
// addresses and u_dut4 with 4, the latter for the address-exhaustion case.
// A negedge monitor records every pixel write, checks strobe setup/hold/width
// and pops the expected {addr, data} pairs from a queue per instance.
// -----------------------------------------------------------------------------
module tb_sti_pixel_packer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset    = 1'b0;
    logic       so_data  = 1'b0;
    logic       so_valid = 1'b0;
    logic       pi_end   = 1'b0;

    logic       wr0, fin0, ovf0;
    logic [7:0] addr0, data0;
    logic       wr1, fin1, ovf1;
    logic [7:0] addr1, data1;

    sti_pixel_packer #(.PIX_DEPTH(256), .ADDR_W(8)) u_dut (
        .clk(clk), .reset(reset), .so_data(so_data), .so_valid(so_valid),
        .pi_end(pi_end), .pixel_wr(wr0), .pixel_addr(addr0),
        .pixel_dataout(data0), .pixel_finish(fin0), .overflow(ovf0)
    );

    sti_pixel_packer #(.PIX_DEPTH(4), .ADDR_W(8)) u_dut4 (
        .clk(clk), .reset(reset), .so_data(so_data), .so_valid(so_valid),
        .pi_end(pi_end), .pixel_wr(wr1), .pixel_addr(addr1),
        .pixel_dataout(data1), .pixel_finish(fin1), .overflow(ovf1)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_q4[$];
    int          wr_cnt[2];
    logic        p_wr[2];
    logic [7:0]  p_addr[2];
    logic [7:0]  p_data[2];
    bit          chk_en[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic mon(input int k, input logic wr, input logic [7:0] a, input logic [7:0] d);
        logic [15:0] e;
        if (reset == 1'b0) begin
            p_wr[k]   = 1'b0;
            p_addr[k] = a;
            p_data[k] = d;
            return;
        end
        if (!p_wr[k] && wr) begin
            check($sformatf("d%0d_setup_addr", k), a, p_addr[k]);
            check($sformatf("d%0d_setup_data", k), d, p_data[k]);
            wr_cnt[k]++;
            if (chk_en[k]) begin
                if ((k == 0 ? exp_q.size() : exp_q4.size()) == 0) begin
                    check($sformatf("d%0d_unexpected_write", k), {a, d}, 32'hFFFF_FFFF);
                end else begin
                    e = (k == 0) ? exp_q.pop_front() : exp_q4.pop_front();
                    check($sformatf("d%0d_write_addr_data", k), {a, d}, e);
                end
            end
        end else if (p_wr[k]) begin
            check($sformatf("d%0d_strobe_width", k), wr, 1'b0);
            check($sformatf("d%0d_hold_addr", k), a, p_addr[k]);
            check($sformatf("d%0d_hold_data", k), d, p_data[k]);
        end
        p_wr[k]   = wr;
        p_addr[k] = a;
        p_data[k] = d;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            wr_cnt[k] = 0;
            p_wr[k]   = 1'b0;
            p_addr[k] = 8'h00;
            p_data[k] = 8'h00;
            chk_en[k] = 1'b0;
        end
    end

    always @(negedge clk) begin
        mon(0, wr0, addr0, data0);
        mon(1, wr1, addr1, data1);
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        so_valid = 1'b0;
        so_data  = 1'b0;
        pi_end   = 1'b0;
        exp_q.delete();
        exp_q4.delete();
        wr_cnt[0] = 0;
        wr_cnt[1] = 0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
    endtask

    // Sends bits MSB-first, then drops so_valid for one cycle.
    task automatic send_bits(input int n, input logic [39:0] bits);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            so_valid = 1'b1;
            so_data  = bits[i];
        end
        @(negedge clk);
        so_valid = 1'b0;
        so_data  = 1'b0;
    endtask

    task automatic load_exp(input int n_exp, input logic [31:0] exp_b);
        logic [7:0] b;
        logic [7:0] a8;
        exp_q.delete();
        for (int a = 0; a < 256; a++) begin
            a8 = 8'(a);
            if (a < n_exp) b = exp_b[8*(n_exp-1-a) +: 8];
            else           b = 8'h00;
            exp_q.push_back({a8, b});
        end
    endtask

    task automatic wait_finish(input int k, input int budget, output int cyc);
        cyc = 0;
        while (((k == 0) ? fin0 : fin1) !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int          nb1;
        logic [39:0] f1;
        int          nb2;   // 0: frame 1 is the final frame
        logic [39:0] f2;
        int          n_exp; // leading non-zero-fill pixels
        logic [31:0] exp_b; // those pixels, first one in the top used byte
    } case_t;

    case_t cases[6];

    initial begin
        int cyc;
        int lo;
        int cnt_before;
        bit found;

        cases[0] = '{16, 40'hA55A,  0, 40'h0,      2, 32'hA55A};
        cases[1] = '{ 8, 40'h3C,   24, 40'h123456, 4, 32'h3C123456};
        cases[2] = '{12, 40'hB6D,   0, 40'h0,      2, 32'hB6D0};
        cases[3] = '{ 9, 40'h0FF,   0, 40'h0,      2, 32'h7F80};
        cases[4] = '{ 7, 40'h55,    0, 40'h0,      1, 32'hAA};
        cases[5] = '{ 4, 40'hC,    12, 40'h3A5,    2, 32'hC3A5};

        // Reset state, checked while reset is still held.
        repeat (2) @(negedge clk);
        check("rst_wr",       wr0,   1'b0);
        check("rst_addr",     addr0, 8'h00);
        check("rst_data",     data0, 8'h00);
        check("rst_finish",   fin0,  1'b0);
        check("rst_overflow", ovf0,  1'b0);
        check("rst4_wr",      wr1,   1'b0);
        check("rst4_finish",  fin1,  1'b0);
        check("rst4_overflow", ovf1, 1'b0);

        // Table-driven frames on the 256-address instance.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            chk_en[0] = 1'b1;
            chk_en[1] = 1'b0;
            load_exp(cases[i].n_exp, cases[i].exp_b);
            if (cases[i].nb2 == 0) begin
                pi_end = 1'b1;
                send_bits(cases[i].nb1, cases[i].f1);
            end else begin
                pi_end = 1'b0;
                send_bits(cases[i].nb1, cases[i].f1);
                repeat (4) @(negedge clk);
                pi_end = 1'b1;
                send_bits(cases[i].nb2, cases[i].f2);
            end
            wait_finish(0, 1000, cyc);
            pi_end = 1'b0;
            lo = 3 * (256 - cases[i].n_exp);
            check_range($sformatf("c%0d_finish_latency", i), cyc, lo, lo + 10);
            repeat (10) @(negedge clk);
            check($sformatf("c%0d_write_count", i), wr_cnt[0], 256);
            check($sformatf("c%0d_exp_left", i), exp_q.size(), 0);
            check($sformatf("c%0d_finish_sticky", i), fin0, 1'b1);
            check($sformatf("c%0d_overflow", i), ovf0, 1'b0);
        end

        // Address exhaustion on the 4-address instance: 40 bits of ones.
        do_reset();
        chk_en[0] = 1'b0;
        chk_en[1] = 1'b1;
        for (int a = 0; a < 4; a++) exp_q4.push_back({8'(a), 8'hFF});
        pi_end = 1'b0;
        send_bits(32, 40'hFF_FFFF_FFFF);
        repeat (5) @(negedge clk);
        check("ovf_four_writes", wr_cnt[1], 4);
        check("ovf_not_yet", ovf1, 1'b0);
        check("ovf_no_finish_yet", fin1, 1'b0);
        pi_end = 1'b1;
        send_bits(8, 40'hFF);
        check("ovf_set", ovf1, 1'b1);
        wait_finish(1, 50, cyc);
        pi_end = 1'b0;
        check("ovf_finish_latency", cyc, 2);
        repeat (10) @(negedge clk);
        check("ovf_no_extra_write", wr_cnt[1], 4);
        check("ovf_exp_left", exp_q4.size(), 0);
        check("ovf_sticky", ovf1, 1'b1);
        check("ovf_finish_sticky", fin1, 1'b1);

        // Reset while filling address 100, then a fresh stream.
        do_reset();
        chk_en[0] = 1'b1;
        chk_en[1] = 1'b0;
        load_exp(2, 32'hA55A);
        pi_end = 1'b1;
        send_bits(16, 40'hA55A);
        found = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
            @(negedge clk);
            if (addr0 == 8'd100 && wr0 == 1'b1) found = 1'b1;
        end
        check("abort_reached_addr100", found, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("abort_wr",     wr0,   1'b0);
        check("abort_addr",   addr0, 8'h00);
        check("abort_data",   data0, 8'h00);
        check("abort_finish", fin0,  1'b0);
        exp_q.delete();
        cnt_before = wr_cnt[0];
        pi_end = 1'b0;
        repeat (5) @(negedge clk);
        #1 reset = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_write_after", wr_cnt[0], cnt_before);
        load_exp(1, 32'h81);
        pi_end = 1'b1;
        send_bits(8, 40'h81);
        wait_finish(0, 1000, cyc);
        pi_end = 1'b0;
        check_range("restart_finish_latency", cyc, 765, 775);
        repeat (5) @(negedge clk);
        check("restart_write_count", wr_cnt[0], cnt_before + 256);
        check("restart_exp_left", exp_q.size(), 0);
        check("restart_finish", fin0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
